// File: rtl/fifo_pkg.sv
// Shared definitions for the dual-clock FIFO: skid-buffer states,
// Gray/binary pointer conversion and depth helpers.
package fifo_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } skid_state_t;

    localparam int unsigned DEFAULT_ADDRSIZE = 4;
    localparam int unsigned DEFAULT_DEPTH    = 1 << DEFAULT_ADDRSIZE;

    function automatic int unsigned fifo_depth(input int unsigned addrsize);
        return 1 << addrsize;
    endfunction

    // Pointers are passed zero-extended to 32 bits; leading zeros do not
    // disturb either conversion.
    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b[31] = g[31];
        for (int i = 30; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/fifo_wr_frontend_sync_r2w.sv
// Two-flop synchronizer bringing the Gray read pointer into the write clock domain.
module sync_r2w #(
    parameter int W = 5
) (
    input  logic         wclk,
    input  logic         wrst_n,
    input  logic [W-1:0] rptr,
    output logic [W-1:0] wq2_rptr
);

    logic [W-1:0] wq1_rptr;

    // Nothing combinational ahead of the first flop: rptr is Gray-coded and
    // only one bit may change per read-clock edge.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            wq1_rptr <= '0;
            wq2_rptr <= '0;
        end else begin
            wq1_rptr <= rptr;
            wq2_rptr <= wq1_rptr;
        end
    end

endmodule

// File: rtl/fifo_wr_frontend.sv
// Write-domain front end: 2-entry skid buffer onto the FIFO write port, read-pointer
// synchronizer, and occupancy / almost-full / pointer-consistency reporting.
module fifo_wr_frontend
    import fifo_pkg::*;
#(
    parameter int ADDRSIZE     = 4,
    parameter int DATASIZE     = 8,
    parameter int AFULL_THRESH = 12
) (
    input  logic                wclk,
    input  logic                wrst_n,
    input  logic                s_valid,
    input  logic [DATASIZE-1:0] s_data,
    output logic                s_ready,
    input  logic                wfull,
    input  logic [ADDRSIZE:0]   wptr,
    input  logic [ADDRSIZE:0]   rptr,
    input  logic                err_clr,
    output logic                winc,
    output logic [DATASIZE-1:0] wdata,
    output logic [ADDRSIZE:0]   wq2_rptr,
    output logic [ADDRSIZE:0]   wlevel,
    output logic                walmost_full,
    output logic                ptr_err
);

    localparam int PW = ADDRSIZE + 1;
    localparam logic [PW-1:0] DEPTH_P = PW'(fifo_depth(ADDRSIZE));
    localparam logic [PW-1:0] AFULL_P = PW'(AFULL_THRESH);

    skid_state_t         state, state_nxt;
    logic [DATASIZE-1:0] entry0, entry1;
    logic [DATASIZE-1:0] entry0_nxt, entry1_nxt;
    logic                push, pop;

    // Handshake is driven only from registered state and the registered wfull.
    assign s_ready = (state != ST_TWO);
    assign winc    = (state != ST_EMPTY) & ~wfull;
    assign wdata   = entry0;
    assign push    = s_valid & s_ready;
    assign pop     = winc;

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            state  <= ST_EMPTY;
            entry0 <= '0;
            entry1 <= '0;
        end else begin
            state  <= state_nxt;
            entry0 <= entry0_nxt;
            entry1 <= entry1_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        entry0_nxt = entry0;
        entry1_nxt = entry1;
        unique case (state)
            ST_EMPTY: begin
                if (push) begin
                    state_nxt  = ST_ONE;
                    entry0_nxt = s_data;
                end
            end
            ST_ONE: begin
                if (push && pop) begin
                    entry0_nxt = s_data;
                end else if (push) begin
                    state_nxt  = ST_TWO;
                    entry1_nxt = s_data;
                end else if (pop) begin
                    state_nxt  = ST_EMPTY;
                end
            end
            ST_TWO: begin
                // s_ready is low here, so only a pop can happen.
                if (pop) begin
                    state_nxt  = ST_ONE;
                    entry0_nxt = entry1;
                end
            end
            default: state_nxt = ST_EMPTY;
        endcase
    end

    sync_r2w #(.W(PW)) u_sync_r2w (
        .wclk     (wclk),
        .wrst_n   (wrst_n),
        .rptr     (rptr),
        .wq2_rptr (wq2_rptr)
    );

    logic [PW-1:0] rbin, wbin, lvl;

    // Modulo-2**PW subtraction absorbs pointer wrap-around.
    assign rbin = PW'(gray2bin(32'(wq2_rptr)));
    assign wbin = PW'(gray2bin(32'(wptr)));
    assign lvl  = wbin - rbin;

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            wlevel       <= '0;
            walmost_full <= 1'b0;
            ptr_err      <= 1'b0;
        end else begin
            wlevel       <= lvl;
            walmost_full <= (lvl >= AFULL_P);
            ptr_err      <= (lvl > DEPTH_P) | (ptr_err & ~err_clr);
        end
    end

endmodule

// File: tb/tb_fifo_wr_frontend.sv
// Directed and scoreboard bench for the FIFO write-domain front end.
module tb_fifo_wr_frontend;

    localparam int AW = 4;
    localparam int DW = 8;

    logic          wclk;
    logic          wrst_n;
    logic          s_valid;
    logic [DW-1:0] s_data;
    logic          s_ready;
    logic          wfull;
    logic [AW:0]   wptr;
    logic [AW:0]   rptr;
    logic          err_clr;
    logic          winc;
    logic [DW-1:0] wdata;
    logic [AW:0]   wq2_rptr;
    logic [AW:0]   wlevel;
    logic          walmost_full;
    logic          ptr_err;

    int n_vec  = 0;
    int n_miss = 0;
    logic [DW-1:0] sb[$];
    logic [DW-1:0] exp_w;

    fifo_wr_frontend #(.ADDRSIZE(AW), .DATASIZE(DW), .AFULL_THRESH(12)) dut (
        .wclk         (wclk),
        .wrst_n       (wrst_n),
        .s_valid      (s_valid),
        .s_data       (s_data),
        .s_ready      (s_ready),
        .wfull        (wfull),
        .wptr         (wptr),
        .rptr         (rptr),
        .err_clr      (err_clr),
        .winc         (winc),
        .wdata        (wdata),
        .wq2_rptr     (wq2_rptr),
        .wlevel       (wlevel),
        .walmost_full (walmost_full),
        .ptr_err      (ptr_err)
    );

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [AW:0] g(input int n);
        logic [AW:0] b;
        b = (AW+1)'(n);
        return b ^ (b >> 1);
    endfunction

    task automatic step();
        @(posedge wclk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, want finish");
        $fatal(1);
    end

    initial begin
        wrst_n = 1'b0; s_valid = 1'b0; s_data = '0; wfull = 1'b0;
        wptr = '0; rptr = '0; err_clr = 1'b0;
        #2;
        chk("rst_s_ready", s_ready, 1);
        chk("rst_winc", winc, 0);
        chk("rst_wdata", wdata, 0);
        chk("rst_wq2_rptr", wq2_rptr, 0);
        chk("rst_wlevel", wlevel, 0);
        chk("rst_afull", walmost_full, 0);
        chk("rst_ptr_err", ptr_err, 0);
        #10 wrst_n = 1'b1;

        // Streaming at one word per cycle
        step();
        s_valid = 1'b1; s_data = 8'h01;
        #1;
        chk("s1_pre_winc", winc, 0);
        chk("s1_pre_ready", s_ready, 1);
        for (int i = 1; i <= 5; i++) begin
            step();
            chk("s1_winc", winc, 1);
            chk("s1_wdata", wdata, i);
            chk("s1_ready", s_ready, 1);
            if (i < 5) s_data = DW'(i + 1);
            else s_valid = 1'b0;
        end
        step();
        chk("s1_idle_winc", winc, 0);

        // Backpressure from wfull
        wfull = 1'b1; s_valid = 1'b1; s_data = 8'hA0;
        step();
        chk("s2_ready_one", s_ready, 1);
        chk("s2_winc_full1", winc, 0);
        s_data = 8'hA1;
        step();
        chk("s2_ready_two", s_ready, 0);
        chk("s2_winc_full2", winc, 0);
        s_data = 8'hA2;
        step();
        chk("s2_ready_hold", s_ready, 0);
        chk("s2_winc_full3", winc, 0);
        wfull = 1'b0;
        #1;
        chk("s2_resume_winc", winc, 1);
        chk("s2_wdata_a0", wdata, 8'hA0);
        step();
        chk("s2_wdata_a1", wdata, 8'hA1);
        chk("s2_ready_back", s_ready, 1);
        step();
        chk("s2_wdata_a2", wdata, 8'hA2);
        chk("s2_winc_a2", winc, 1);
        s_valid = 1'b0;
        step();
        chk("s2_idle_winc", winc, 0);

        // Random valid and wfull against a scoreboard
        for (int c = 0; c < 3000; c++) begin
            s_valid = 1'($urandom_range(0, 1));
            s_data  = DW'($urandom);
            wfull   = ($urandom_range(0, 3) == 0);
            #1;
            chk("rnd_no_wr_full", winc & wfull, 0);
            if (winc) begin
                chk("rnd_sb_nonempty", sb.size() > 0, 1);
                if (sb.size() > 0) begin
                    exp_w = sb.pop_front();
                    chk("rnd_order", wdata, exp_w);
                end
            end
            if (s_valid && s_ready) sb.push_back(s_data);
            step();
        end
        s_valid = 1'b0; wfull = 1'b0;
        for (int c = 0; c < 6; c++) begin
            #1;
            if (winc && sb.size() > 0) begin
                exp_w = sb.pop_front();
                chk("rnd_drain", wdata, exp_w);
            end
            step();
        end
        chk("rnd_sb_empty", sb.size(), 0);
        chk("rnd_end_winc", winc, 0);

        // Level and almost-full
        wptr = g(12); rptr = g(0);
        step(); step(); step();
        chk("lv_level12", wlevel, 12);
        chk("lv_afull12", walmost_full, 1);
        chk("lv_err12", ptr_err, 0);
        rptr = g(1);
        step(); step();
        chk("lv_wq2_rptr", wq2_rptr, g(1));
        chk("lv_level_lag", wlevel, 12);
        step();
        chk("lv_level11", wlevel, 11);
        chk("lv_afull11", walmost_full, 0);

        // Wrap-around and pointer error
        rptr = g(27); wptr = g(3);
        step(); step(); step();
        chk("wr_level8", wlevel, 8);
        chk("wr_err0", ptr_err, 0);
        chk("wr_afull8", walmost_full, 0);
        rptr = g(2);
        step(); step(); step();
        chk("wr_level1", wlevel, 1);
        wptr = g(20);
        step();
        chk("wr_level18", wlevel, 18);
        chk("wr_err_set", ptr_err, 1);
        wptr = g(3);
        step(); step();
        chk("wr_err_sticky", ptr_err, 1);
        chk("wr_level_back", wlevel, 1);
        err_clr = 1'b1;
        step();
        chk("wr_err_clr", ptr_err, 0);
        wptr = g(20);
        step();
        chk("wr_set_wins", ptr_err, 1);
        err_clr = 1'b0; wptr = g(3);
        step();
        chk("wr_err_hold", ptr_err, 1);

        // Asynchronous reset with a full skid buffer
        wptr = g(20);
        wfull = 1'b1; s_valid = 1'b1; s_data = 8'h11;
        step();
        s_data = 8'h22;
        step();
        chk("ar_ready_two", s_ready, 0);
        chk("ar_level18", wlevel, 18);
        wfull = 1'b0; s_valid = 1'b0; wptr = '0; rptr = '0;
        wrst_n = 1'b0;
        #1;
        chk("ar_s_ready", s_ready, 1);
        chk("ar_winc", winc, 0);
        chk("ar_wdata", wdata, 0);
        chk("ar_wlevel", wlevel, 0);
        chk("ar_afull", walmost_full, 0);
        chk("ar_ptr_err", ptr_err, 0);
        chk("ar_wq2_rptr", wq2_rptr, 0);
        @(negedge wclk);
        wrst_n = 1'b1;
        s_valid = 1'b1; s_data = 8'h5A;
        step();
        chk("ar_first_winc", winc, 1);
        chk("ar_first_word", wdata, 8'h5A);
        s_valid = 1'b0;
        step();
        chk("ar_after_winc", winc, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
